// File: rtl/bk_sector_engine.sv
// Backup-RAM sector mover: walks every mounted SD volume sector by sector,
// staging each 512-byte sector in a 256x16 buffer between hps_io and SDRAM.
`timescale 1ns/1ps
module bk_sector_engine #(
  parameter int VOLUMES = 2,
  parameter int ADDR_W = 25,
  parameter logic [VOLUMES*ADDR_W-1:0] BASE_A = {25'h1F00000, 25'h1E00000},
  parameter int MAX_SECT = 256
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [VOLUMES-1:0]  img_mounted,
  input  logic [63:0]         img_size,
  output logic [31:0]         sd_lba,
  output logic [VOLUMES-1:0]  sd_rd,
  output logic [VOLUMES-1:0]  sd_wr,
  input  logic [VOLUMES-1:0]  sd_ack,
  input  logic [7:0]          sd_buff_addr,
  input  logic [15:0]         sd_buff_dout,
  input  logic                sd_buff_wr,
  output logic [15:0]         sd_buff_din,
  input  logic                bk_load,
  input  logic                bk_save,
  output logic                bk_ena,
  output logic                bk_loading,
  output logic                bk_saving,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [15:0]         mem_dout,
  input  logic [15:0]         mem_din,
  input  logic                mem_ack
);

  localparam int NS_W = $clog2(MAX_SECT + 1);
  localparam int CW   = (VOLUMES > 1) ? $clog2(VOLUMES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_VSEL, S_SD_REQ, S_SD_XFER, S_MEM_XFER, S_NEXT
  } state_t;

  state_t st, st_nx;

  logic               load_p1, save_p1, ack_p1, is_load, req;
  logic [CW-1:0]      cur, sel;
  logic [CW:0]        vol;
  logic [NS_W-1:0]    lba, lba_inc, ns_cur;
  logic [NS_W-1:0]    nsect   [VOLUMES];
  logic [NS_W-1:0]    pend_ns [VOLUMES];
  logic [VOLUMES-1:0] pend, oh;
  logic [7:0]         idx;
  logic [ADDR_W-1:0]  base_cur;
  logic               found, any_ns, ack_cur, rise_ld, rise_sv;
  logic               unused_sz;

  logic [15:0] bram [256];
  logic [15:0] buf_q, buf_wd;
  logic [7:0]  buf_addr;
  logic        buf_we;

  function automatic logic [NS_W-1:0] sat_sect(input logic [54:0] sec);
    if (sec > 55'(MAX_SECT)) return NS_W'(MAX_SECT);
    return sec[NS_W-1:0];
  endfunction

  assign unused_sz = ^img_size[8:0];
  assign rise_ld   = (st == S_IDLE) && bk_load && !load_p1;
  assign rise_sv   = (st == S_IDLE) && bk_save && !save_p1 && !rise_ld;
  assign lba_inc   = lba + NS_W'(1);
  assign ack_cur   = |(sd_ack & oh);

  always_comb begin
    oh       = '0;
    base_cur = '0;
    ns_cur   = '0;
    any_ns   = 1'b0;
    for (int v = 0; v < VOLUMES; v++) begin
      oh[v] = (cur == CW'(v));
      if (cur == CW'(v)) begin
        base_cur = BASE_A[v*ADDR_W +: ADDR_W];
        ns_cur   = nsect[v];
      end
      if (nsect[v] != '0) any_ns = 1'b1;
    end
  end

  // Lowest mounted volume at or above vol; scanning downward lets the lowest win.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int v = VOLUMES - 1; v >= 0; v--) begin
      if (v >= int'(vol) && nsect[v] != '0) begin
        found = 1'b1;
        sel   = CW'(v);
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) st <= S_IDLE;
    else       st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    case (st)
      S_IDLE:     if (rise_ld || rise_sv) st_nx = S_VSEL;
      S_VSEL:     if (!found) st_nx = S_IDLE;
                  else        st_nx = is_load ? S_SD_REQ : S_MEM_XFER;
      S_SD_REQ:   if (ack_cur) st_nx = S_SD_XFER;
      S_SD_XFER:  if (ack_p1 && !ack_cur) st_nx = is_load ? S_MEM_XFER : S_NEXT;
      S_MEM_XFER: if (req && mem_ack && idx == 8'hFF) st_nx = is_load ? S_NEXT : S_SD_REQ;
      S_NEXT:     if (lba_inc == ns_cur) st_nx = S_VSEL;
                  else                   st_nx = is_load ? S_SD_REQ : S_MEM_XFER;
      default:    st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      load_p1    <= 1'b0;
      save_p1    <= 1'b0;
      ack_p1     <= 1'b0;
      is_load    <= 1'b0;
      bk_loading <= 1'b0;
      bk_saving  <= 1'b0;
      bk_ena     <= 1'b0;
      req        <= 1'b0;
      idx        <= '0;
      lba        <= '0;
      cur        <= '0;
      vol        <= '0;
      pend       <= '0;
      for (int v = 0; v < VOLUMES; v++) begin
        nsect[v]   <= '0;
        pend_ns[v] <= '0;
      end
    end else begin
      load_p1 <= bk_load;
      save_p1 <= bk_save;
      ack_p1  <= ack_cur;
      bk_ena  <= any_ns;
      if (rise_ld || rise_sv) begin
        is_load    <= rise_ld;
        bk_loading <= rise_ld;
        bk_saving  <= rise_sv;
        vol        <= '0;
      end else if (st_nx == S_IDLE) begin
        bk_loading <= 1'b0;
        bk_saving  <= 1'b0;
      end
      case (st)
        S_VSEL: begin
          if (found) cur <= sel;
          lba <= '0;
          idx <= '0;
          req <= 1'b0;
        end
        S_MEM_XFER: begin
          if (!req) req <= 1'b1;
          else if (mem_ack) begin
            req <= 1'b0;
            idx <= idx + 8'd1;
          end
        end
        S_NEXT: begin
          lba <= lba_inc;
          if (lba_inc == ns_cur) vol <= {1'b0, cur} + (CW+1)'(1);
        end
        default: ;
      endcase
      // Sector counts stay frozen while busy; mounts then wait in pend.
      for (int v = 0; v < VOLUMES; v++) begin
        if (img_mounted[v]) begin
          if (st == S_IDLE) begin
            nsect[v] <= sat_sect(img_size[63:9]);
            pend[v]  <= 1'b0;
          end else begin
            pend_ns[v] <= sat_sect(img_size[63:9]);
            pend[v]    <= 1'b1;
          end
        end else if (st == S_IDLE && pend[v]) begin
          nsect[v] <= pend_ns[v];
          pend[v]  <= 1'b0;
        end
      end
    end
  end

  // Single-port buffer: MEM_XFER owns the address, otherwise hps_io does.
  always_comb begin
    buf_addr = (st == S_MEM_XFER) ? idx : sd_buff_addr;
    buf_wd   = is_load ? sd_buff_dout : mem_din;
    buf_we   = (is_load && sd_buff_wr && (st == S_SD_REQ || st == S_SD_XFER)) ||
               (!is_load && st == S_MEM_XFER && req && mem_ack);
  end

  always_ff @(posedge clk_sys) begin
    if (buf_we) bram[buf_addr] <= buf_wd;
    buf_q <= bram[buf_addr];
  end

  assign sd_lba      = {{(32-NS_W){1'b0}}, lba};
  assign sd_rd       = (st == S_SD_REQ && is_load)  ? oh : '0;
  assign sd_wr       = (st == S_SD_REQ && !is_load) ? oh : '0;
  assign sd_buff_din = (!is_load && (st == S_SD_REQ || st == S_SD_XFER)) ? buf_q : 16'h0;
  assign mem_rd      = req && !is_load;
  assign mem_wr      = req && is_load;
  assign mem_dout    = (req && is_load) ? buf_q : 16'h0;
  assign mem_addr    = req ? (base_cur + {{(ADDR_W-NS_W-9){1'b0}}, lba, 9'b0}
                                       + {{(ADDR_W-9){1'b0}}, idx, 1'b0}) : '0;

endmodule

// File: tb/tb_bk_sector_engine.sv
// Directed-sequence bench for bk_sector_engine with random sector contents,
// behavioural hps_io / SDRAM responders and a request-order reference model.
`timescale 1ns/1ps
module tb_bk_sector_engine;

  localparam int VOLUMES  = 2;
  localparam int ADDR_W   = 25;
  localparam int MAX_SECT = 8;
  localparam int WORDS    = MAX_SECT * 256;
  localparam logic [ADDR_W-1:0] BASE0 = 25'h1E00000;
  localparam logic [ADDR_W-1:0] BASE1 = 25'h1F00000;

  logic clk_sys = 1'b0;
  logic reset;
  logic [VOLUMES-1:0] img_mounted;
  logic [63:0] img_size;
  logic [31:0] sd_lba;
  logic [VOLUMES-1:0] sd_rd, sd_wr, sd_ack;
  logic [7:0] sd_buff_addr;
  logic [15:0] sd_buff_dout, sd_buff_din;
  logic sd_buff_wr, bk_load, bk_save, bk_ena, bk_loading, bk_saving;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_rd, mem_wr, mem_ack;
  logic [15:0] mem_dout, mem_din;

  always #5 clk_sys = ~clk_sys;

  bk_sector_engine #(
    .VOLUMES(VOLUMES), .ADDR_W(ADDR_W), .BASE_A({BASE1, BASE0}), .MAX_SECT(MAX_SECT)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_size(img_size),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .bk_load(bk_load), .bk_save(bk_save), .bk_ena(bk_ena),
    .bk_loading(bk_loading), .bk_saving(bk_saving), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_ack(mem_ack)
  );

  typedef struct { int v; int lba; bit wr; } req_t;

  logic [15:0] img     [VOLUMES][WORDS];
  logic [15:0] out_f   [VOLUMES][WORDS];
  logic [15:0] pre_mem [VOLUMES][WORDS];
  logic [15:0] sdram   [int];
  req_t log_q[$];
  int ns_m [VOLUMES];
  int mem_wr_cnt = 0, odd_cnt = 0, multi_cnt = 0, sav_cyc = 0;
  int n_assert = 0, n_fail = 0;

  function automatic int base_w(int v);
    return (v == 0) ? int'(BASE0) / 2 : int'(BASE1) / 2;
  endfunction

  function automatic logic [15:0] mem_val(int wa);
    if (sdram.exists(wa)) return sdram[wa];
    for (int v = 0; v < VOLUMES; v++)
      if (wa >= base_w(v) && wa < base_w(v) + WORDS) return pre_mem[v][wa - base_w(v)];
    return 16'h0;
  endfunction

  // hps_io model: one word per cycle on load, read back every other cycle on save
  initial begin : sd_model
    req_t r;
    int idx;
    sd_ack = '0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!reset && (sd_rd | sd_wr) != '0) begin
        r.v   = (sd_rd[1] | sd_wr[1]) ? 1 : 0;
        r.wr  = |sd_wr;
        r.lba = int'(sd_lba);
        log_q.push_back(r);
        sd_ack = '0;
        sd_ack[r.v] = 1'b1;
        for (int i = 0; i < 256; i++) begin
          @(negedge clk_sys);
          if (reset) break;
          sd_buff_addr = 8'(i);
          idx = r.lba * 256 + i;
          if (!r.wr) begin
            sd_buff_dout = (idx < WORDS) ? img[r.v][idx] : 16'h0;
            sd_buff_wr = 1'b1;
          end else begin
            @(negedge clk_sys);
            if (reset) break;
            if (idx < WORDS) out_f[r.v][idx] = sd_buff_din;
          end
        end
        @(negedge clk_sys);
        sd_buff_wr = 1'b0;
        sd_ack = '0;
      end
    end
  end

  // SDRAM model: acknowledge each request one cycle after it is seen
  initial begin : mem_model
    int wa;
    mem_ack = 1'b0; mem_din = '0;
    forever begin
      @(negedge clk_sys);
      if (!reset && (mem_rd || mem_wr)) begin
        wa = int'(mem_addr >> 1);
        if (mem_addr[0]) odd_cnt++;
        if (mem_wr) begin
          sdram[wa] = mem_dout;
          mem_wr_cnt++;
        end else mem_din = mem_val(wa);
        mem_ack = 1'b1;
        @(negedge clk_sys);
        mem_ack = 1'b0;
      end
    end
  end

  always @(negedge clk_sys) begin
    if ($countones(sd_rd | sd_wr) > 1) multi_cnt++;
    if (bk_saving) sav_cyc++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, {sd_lba, sd_rd, sd_wr, sd_buff_din, bk_ena, bk_loading, bk_saving,
              mem_addr, mem_rd, mem_wr, mem_dout}, 128'd0);
  endtask

  task automatic mount(input int v, input logic [63:0] sz);
    img_mounted = '0;
    img_mounted[v] = 1'b1;
    img_size = sz;
    tick(1);
    img_mounted = '0;
    ns_m[v] = ((sz >> 9) > 64'(MAX_SECT)) ? MAX_SECT : int'(sz >> 9);
  endtask

  task automatic fill_img(input int v);
    for (int k = 0; k < WORDS; k++) img[v][k] = 16'($urandom);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40000; c++) begin
      if (!bk_loading && !bk_saving) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic run_op(input bit ld, input bit sv, output bit ok);
    bk_load = ld; bk_save = sv;
    tick(2);
    bk_load = 1'b0; bk_save = 1'b0;
    wait_idle(ok);
  endtask

  // Expected request order: every mounted volume ascending, lba 0..nsect-1
  task automatic chk_log(input string tag, input int start, input bit wr);
    req_t exp_q[$];
    req_t r;
    int errs = 0;
    for (int v = 0; v < VOLUMES; v++)
      for (int l = 0; l < ns_m[v]; l++) begin
        r.v = v; r.lba = l; r.wr = wr;
        exp_q.push_back(r);
      end
    chk({tag, "_req_count"}, log_q.size() - start, exp_q.size());
    for (int k = 0; k < exp_q.size() && start + k < log_q.size(); k++)
      if (log_q[start+k].v != exp_q[k].v || log_q[start+k].lba != exp_q[k].lba ||
          log_q[start+k].wr != exp_q[k].wr) errs++;
    chk({tag, "_req_order"}, errs, 0);
  endtask

  task automatic verify_load(input string tag, input int v);
    int errs = 0;
    for (int k = 0; k < ns_m[v] * 256; k++)
      if (!sdram.exists(base_w(v) + k) || sdram[base_w(v) + k] !== img[v][k]) errs++;
    chk(tag, errs, 0);
  endtask

  task automatic verify_save(input string tag, input int v);
    int errs = 0;
    for (int k = 0; k < ns_m[v] * 256; k++)
      if (out_f[v][k] !== mem_val(base_w(v) + k)) errs++;
    chk(tag, errs, 0);
  endtask

  initial begin : main
    bit ok;
    int s_log, s_wr, s_multi, s_sav, busy;
    reset = 1'b1; bk_load = 1'b0; bk_save = 1'b0; img_mounted = '0; img_size = '0;
    for (int v = 0; v < VOLUMES; v++) begin
      ns_m[v] = 0;
      fill_img(v);
      for (int k = 0; k < WORDS; k++) pre_mem[v][k] = 16'($urandom);
    end
    tick(3);
    chk_outs_zero("reset_outputs");
    reset = 1'b0;
    tick(2);
    chk("bk_ena_after_reset", bk_ena, 0);

    // 1 KiB image on vol0 only
    mount(0, 64'h400);
    tick(2);
    chk("bk_ena_mounted", bk_ena, 1);
    s_log = log_q.size(); s_wr = mem_wr_cnt;
    run_op(1'b1, 1'b0, ok);
    chk("t1_finished", ok, 1);
    chk_log("t1", s_log, 1'b0);
    chk("t1_mem_wr_count", mem_wr_cnt - s_wr, 512);
    verify_load("t1_sdram_data", 0);
    chk("t1_loading_low", bk_loading, 0);

    // Save both volumes, vol0 capped at MAX_SECT
    mount(0, 64'h20000);
    mount(1, 64'h1000);
    s_log = log_q.size(); s_wr = mem_wr_cnt; s_multi = multi_cnt;
    run_op(1'b0, 1'b1, ok);
    chk("t2_finished", ok, 1);
    chk_log("t2", s_log, 1'b1);
    chk("t2_sd_wr_onehot", multi_cnt - s_multi, 0);
    chk("t2_no_mem_wr", mem_wr_cnt - s_wr, 0);
    verify_save("t2_file_vol0", 0);
    verify_save("t2_file_vol1", 1);
    chk("t2_saving_low", bk_saving, 0);

    // Size above the cap: load stops at lba MAX_SECT-1
    mount(0, 64'h30000);
    mount(1, 64'h0);
    fill_img(0);
    s_log = log_q.size();
    run_op(1'b1, 1'b0, ok);
    chk("t3_finished", ok, 1);
    chk_log("t3", s_log, 1'b0);
    chk("t3_last_lba", (log_q.size() > 0) ? log_q[log_q.size()-1].lba : -1, MAX_SECT - 1);
    verify_load("t3_sdram_data", 0);

    // Remainder below one sector is ignored
    mount(0, 64'h3FF);
    s_log = log_q.size();
    run_op(1'b1, 1'b0, ok);
    chk("t4_finished", ok, 1);
    chk_log("t4", s_log, 1'b0);

    // Simultaneous edges: load wins; a save edge while busy is ignored
    mount(0, 64'h600);
    fill_img(0);
    s_log = log_q.size(); s_sav = sav_cyc;
    bk_load = 1'b1; bk_save = 1'b1;
    tick(2);
    bk_load = 1'b0; bk_save = 1'b0;
    tick(300);
    chk("t5_loading_mid", bk_loading, 1);
    bk_save = 1'b1;
    tick(2);
    bk_save = 1'b0;
    wait_idle(ok);
    chk("t5_finished", ok, 1);
    chk("t5_saving_never", sav_cyc - s_sav, 0);
    chk_log("t5", s_log, 1'b0);
    verify_load("t5_sdram_data", 0);

    // Reset in the middle of sector 3, then a clean restart
    mount(0, 64'h1000);
    fill_img(0);
    s_log = log_q.size();
    bk_load = 1'b1;
    tick(2);
    bk_load = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (log_q.size() - s_log >= 4) begin ok = 1'b1; break; end
      tick(1);
    end
    chk("t6_reached_sector3", ok, 1);
    tick(60);
    chk("t6_xfer_lba", sd_lba, 3);
    #2 reset = 1'b1;
    #1 chk_outs_zero("t6_reset_outputs");
    tick(3);
    reset = 1'b0;
    for (int v = 0; v < VOLUMES; v++) ns_m[v] = 0;
    tick(2);
    chk("t6_bk_ena_cleared", bk_ena, 0);
    mount(0, 64'h400);
    fill_img(0);
    s_log = log_q.size();
    run_op(1'b1, 1'b0, ok);
    chk("t6_restart_finished", ok, 1);
    chk_log("t6_restart", s_log, 1'b0);
    verify_load("t6_sdram_data", 0);

    // Nothing mounted: short busy pulse and no requests
    mount(0, 64'h0);
    tick(2);
    chk("t7_bk_ena_zero", bk_ena, 0);
    s_log = log_q.size();
    busy = 0;
    bk_load = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (c == 1) bk_load = 1'b0;
      if (bk_loading) busy++;
    end
    chk("t7_busy_le3", busy <= 3, 1);
    chk("t7_no_sd_rd", log_q.size() - s_log, 0);
    chk("t7_even_addresses", odd_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bk_sector_engine.md
Name: bk_sector_engine

Overview:
- Parametrised backup-RAM sector mover between the hps_io SD block interface and an SDRAM word port.
- Generalises the two fixed volumes (SRAM, BMP) to VOLUMES independent volumes, each with its own SDRAM base and size cap.
- On bk_load or bk_save it walks every mounted volume sector by sector through a local 256x16 buffer.
- Sits in pcfx_top between hps_io and memif_sdram, replacing the ad-hoc bk_loading/bk_saving logic.

Parameters:
VOLUMES, 2, number of SD volumes (1..4)
ADDR_W, 25, SDRAM byte-address width
BASE_A, {25'h1F00000,25'h1E00000}, packed VOLUMES*ADDR_W; volume v base = BASE_A[v*ADDR_W +: ADDR_W]
MAX_SECT, 256, per-volume sector cap (128 KiB)

Ports:
clk_sys  in  1  core clock
reset  in  1  asynchronous, active-high reset
img_mounted  in  VOLUMES  one-cycle mount strobe per volume
img_size  in  64  image size in bytes, valid with img_mounted
sd_lba  out  32  sector number for current request
sd_rd  out  VOLUMES  one-hot read request
sd_wr  out  VOLUMES  one-hot write request
sd_ack  in  VOLUMES  transfer in progress, per volume
sd_buff_addr  in  8  word index within sector
sd_buff_dout  in  16  word from SD (load)
sd_buff_wr  in  1  sd_buff_dout strobe
sd_buff_din  out  16  word to SD (save)
bk_load  in  1  rising edge starts load of all volumes
bk_save  in  1  rising edge starts save of all volumes
bk_ena  out  1  any volume has a nonzero sector count
bk_loading  out  1  load in progress
bk_saving  out  1  save in progress
mem_addr  out  ADDR_W  SDRAM byte address, always even
mem_rd  out  1  read request, held until mem_ack
mem_wr  out  1  write request, held until mem_ack
mem_dout  out  16  write data
mem_din  in  16  read data, valid with mem_ack
mem_ack  in  1  one-cycle completion

Behaviour:
- Reset values: all outputs 0; nsect[v] = 0; FSM in IDLE. Reset mid-transfer aborts immediately; the SDRAM image is left partial.
- Mount: on img_mounted[v], nsect[v] = min(img_size>>9, MAX_SECT). Any remainder bytes below 512 are ignored. A mount during a transfer is latched and applied when the FSM returns to IDLE.
- bk_ena = |nsect (registered).
- Start condition: only in IDLE, on a rising edge of bk_load or bk_save. If both rise in the same cycle, load wins. Edges arriving while busy are ignored.
- bk_loading / bk_saving are set in the cycle after the edge and cleared on entry to IDLE.
- States and transitions:
  - IDLE
  - VSEL: picks the lowest v >= vol with nsect[v] != 0. If none, goes to IDLE. lba = 0.
  - Load path: SD_REQ → SD_XFER → MEM_XFER → NEXT.
  - Save path: MEM_XFER → SD_REQ → SD_XFER → NEXT.
  - NEXT: lba++. If lba == nsect[v], then vol = v+1 and go to VSEL; otherwise continue with the next sector.
- SD_REQ: drive sd_lba = lba and sd_rd[v] (load) or sd_wr[v] (save). Hold the request until sd_ack[v] = 1, then deassert it.
- SD_XFER, load: on each sd_buff_wr, buf[sd_buff_addr] <= sd_buff_dout.
- SD_XFER, save: sd_buff_din = buf[sd_buff_addr], registered, one clk_sys of latency; hps_io samples on alternate cycles.
- SD_XFER exit: on the falling edge of sd_ack[v].
- MEM_XFER: runs 256 word accesses, index i = 0..255, with mem_addr = base_v + (lba<<9) + (i<<1).
  - Load: mem_wr with mem_dout = buf[i].
  - Save: mem_rd; on mem_ack, buf[i] <= mem_din.
  - Exactly one outstanding request; the request drops in the cycle after mem_ack.
- Width rule: address arithmetic is ADDR_W wide and wraps silently. Bench configs keep every volume inside the address space.
- Buffer is a single-port 256x16 array, inferred as block RAM.

Test Plan:
- 1 KiB image mounted on vol0, vol1 unmounted; pulse bk_load → exactly 2 sd_rd[0] requests with lba 0 and 1, 512 mem_wr, SDRAM at base0..base0+0x3FE matches the file, then bk_loading falls.
- img_size 0x20000 on vol0 and 0x1000 on vol1; pulse bk_save → 256 sectors written from vol0, then 8 from vol1; output files match SDRAM byte-for-byte; sd_wr is never set on two volumes at once.
- img_size 0x30000 with MAX_SECT 256 → nsect = 256; load stops at lba 255.
- img_size 0x3FF → nsect 1.
- bk_load and bk_save rise in the same cycle → load runs and bk_saving stays 0. A bk_save edge during the load is ignored.
- Assert reset mid SD_XFER of sector 3 → all outputs 0 within the reset cycle; a new bk_load after reset restarts at lba 0.
- No volumes mounted → bk_ena = 0; bk_load pulse raises bk_loading for at most 3 cycles and issues no sd_rd.
